// File: rtl/mips_multicycle_control_pkg.sv
// ----------------------------------------------------------------------------
// mips_multicycle_control_pkg
// Shared constants and types for the multicycle MIPS control unit: opcode and
// funct encodings, ALU function codes, the controller state enumeration, the
// alu_src_b / pc_src mux encodings and the alu_op codes passed from the FSM to
// the ALU decoder.
// ----------------------------------------------------------------------------
package mips_multicycle_control_pkg;

    // Opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (instruction[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALU function codes understood by the datapath ALU.
    // Bit 2 inverts B into the adder, bit 1 selects arithmetic,
    // bit 0 selects the AND/SLT branch.
    localparam logic [2:0] ALU_OR  = 3'b000;
    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // alu_op from the FSM to the ALU decoder. ALUOP_NONE is used in states
    // where the ALU result is unused, so alu_control idles at all-zero.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_NONE  = 2'b11;

    // ALU B-operand select
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP
    } state_t;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// ----------------------------------------------------------------------------
// mips_multicycle_control_if
// Bundle between the control unit and the multicycle datapath.
//   op, funct, zero          : datapath -> control (instruction fields, ALU flag)
//   pc_en .. alu_control     : control -> datapath (enables and mux selects)
// Modport master is the control unit, slave is the datapath.
// ----------------------------------------------------------------------------
interface mips_multicycle_control_if;

    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;

    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_control;

    modport master (
        input  op, funct, zero,
        output pc_en, iord, mem_write, ir_write, mem_to_reg, reg_dst,
               reg_write, alu_src_a, alu_src_b, pc_src, alu_control
    );

    modport slave (
        output op, funct, zero,
        input  pc_en, iord, mem_write, ir_write, mem_to_reg, reg_dst,
               reg_write, alu_src_a, alu_src_b, pc_src, alu_control
    );

endinterface

// File: rtl/mips_multicycle_control_alu_decoder.sv
// ----------------------------------------------------------------------------
// alu_decoder
// Combinational translation of the FSM's alu_op and the instruction funct
// field into the 3-bit ALU function code.
//   funct       in  6  instruction[5:0]
//   alu_op      in  2  00 add, 01 sub, 10 decode funct, 11 idle
//   alu_control out 3  ALU function code
// ----------------------------------------------------------------------------
module alu_decoder
    import mips_multicycle_control_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [1:0] alu_op,
    output logic [2:0] alu_control
);

    // Unrecognised funct values fall back to add so they behave like addu.
    always_comb begin
        alu_control = ALU_OR;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    default:   alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_OR;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// ----------------------------------------------------------------------------
// mips_multicycle_control
// Moore control FSM for the multicycle MIPS datapath. Steps each instruction
// through fetch / decode / execute / memory / writeback and drives every
// datapath enable and mux select.
//   clk      in   rising-edge clock
//   reset_n  in   synchronous active-low reset
//   ctrl     master modport of mips_multicycle_control_if
//            (op, funct, zero in; pc_en, iord, mem_write, ir_write,
//             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_src,
//             alu_control out)
// ----------------------------------------------------------------------------
module mips_multicycle_control
    import mips_multicycle_control_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    mips_multicycle_control_if.master ctrl
);

    state_t     state;
    state_t     next_state;
    logic       is_load;

    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic [2:0] alu_control;

    // State register. The lw/sw distinction is captured while in DECODE so
    // that MEMADR does not depend on op still being held stable.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_RESET;
            is_load <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_DECODE) begin
                is_load <= (ctrl.op == OP_LW);
            end
        end
    end

    // Next-state and Moore outputs.
    always_comb begin
        next_state = state;
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        pc_src     = PCSRC_ALU;
        alu_op     = ALUOP_NONE;

        case (state)
            S_RESET: begin
                next_state = S_FETCH;
            end
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                alu_op     = ALUOP_ADD;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut.
                alu_src_b = SRCB_IMM_SH2;
                alu_op    = ALUOP_ADD;
                case (ctrl.op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXECUTE;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JUMP;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
                if (state == S_ADDIEX) begin
                    next_state = S_ADDIWB;
                end else begin
                    next_state = is_load ? S_MEMRD : S_MEMWR;
                end
            end
            S_MEMRD: begin
                iord       = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_EXECUTE: begin
                alu_src_a  = 1'b1;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                next_state = S_FETCH;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                branch     = 1'b1;
                pc_src     = PCSRC_ALUOUT;
                alu_op     = ALUOP_SUB;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = PCSRC_JUMP;
                next_state = S_FETCH;
            end
            default: begin
                next_state = S_RESET;
            end
        endcase
    end

    alu_decoder u_alu_decoder (
        .funct       (ctrl.funct),
        .alu_op      (alu_op),
        .alu_control (alu_control)
    );

    // zero only matters while branch is high, so pc_en stays low in RESET.
    assign ctrl.pc_en       = pc_write | (branch & ctrl.zero);
    assign ctrl.iord        = iord;
    assign ctrl.mem_write   = mem_write;
    assign ctrl.ir_write    = ir_write;
    assign ctrl.mem_to_reg  = mem_to_reg;
    assign ctrl.reg_dst     = reg_dst;
    assign ctrl.reg_write   = reg_write;
    assign ctrl.alu_src_a   = alu_src_a;
    assign ctrl.alu_src_b   = alu_src_b;
    assign ctrl.pc_src      = pc_src;
    assign ctrl.alu_control = alu_control;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_mips_multicycle_control
// Self-checking bench for the multicycle control unit. Each instruction is
// modelled as a list of per-cycle expected output words indexed by the cycle
// number within the instruction; op/funct carry junk outside the cycles where
// the controller is allowed to look at them.
// ----------------------------------------------------------------------------
module tb_mips_multicycle_control;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    mips_multicycle_control_if bus ();

    mips_multicycle_control dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ctrl    (bus)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output word: {pc_en, iord, mem_write, ir_write, mem_to_reg, reg_dst,
    //               reg_write, alu_src_a, alu_src_b[1:0], pc_src[1:0],
    //               alu_control[2:0]}
    function automatic logic [14:0] observed();
        return {bus.pc_en, bus.iord, bus.mem_write, bus.ir_write,
                bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.pc_src, bus.alu_control};
    endfunction

    // Instruction length in cycles, FETCH included.
    function automatic int cpi(input logic [5:0] o);
        case (o)
            6'b100011: return 5;
            6'b101011: return 4;
            6'b000000: return 4;
            6'b001000: return 4;
            6'b000100: return 3;
            6'b000010: return 3;
            default:   return 2;
        endcase
    endfunction

    function automatic logic [2:0] functCode(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b001;
            6'b100101: return 3'b000;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs in cycle k of an instruction with opcode o.
    function automatic logic [14:0] model(input logic [5:0] o, input logic [5:0] f,
                                          input logic z, input int k);
        logic pe, io, mw, iw, mr, rd, rw, sa;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        {pe, io, mw, iw, mr, rd, rw, sa} = 8'b0;
        sb = 2'b00;
        ps = 2'b00;
        ac = 3'b000;
        if (k == 0) begin
            iw = 1'b1; pe = 1'b1; sb = 2'b01; ac = 3'b010;
        end else if (k == 1) begin
            sb = 2'b11; ac = 3'b010;
        end else begin
            case (o)
                6'b100011, 6'b101011, 6'b001000: begin
                    if (k == 2) begin
                        sa = 1'b1; sb = 2'b10; ac = 3'b010;
                    end else if (o == 6'b100011 && k == 3) begin
                        io = 1'b1;
                    end else if (o == 6'b100011 && k == 4) begin
                        rw = 1'b1; mr = 1'b1;
                    end else if (o == 6'b101011 && k == 3) begin
                        io = 1'b1; mw = 1'b1;
                    end else if (o == 6'b001000 && k == 3) begin
                        rw = 1'b1;
                    end
                end
                6'b000000: begin
                    if (k == 2) begin
                        sa = 1'b1; ac = functCode(f);
                    end else begin
                        rw = 1'b1; rd = 1'b1;
                    end
                end
                6'b000100: begin
                    sa = 1'b1; ps = 2'b01; ac = 3'b110; pe = z;
                end
                6'b000010: begin
                    pe = 1'b1; ps = 2'b10;
                end
                default: ;
            endcase
        end
        return {pe, io, mw, iw, mr, rd, rw, sa, sb, ps, ac};
    endfunction

    task automatic checkOutput(input string tag, input logic [14:0] expected);
        logic [14:0] obs;
        obs = observed();
        checks++;
        assert (obs === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expected);
        end
    endtask

    // Runs one instruction cycle by cycle starting in its FETCH cycle.
    // zsel < 0 randomises zero each cycle. abortAt >= 0 pulls reset_n low
    // during that cycle and checks the following RESET cycle.
    task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f,
                                 input int zsel, input int abortAt);
        int n;
        logic z;
        n = cpi(o);
        for (int k = 0; k < n; k++) begin
            if (k == 1 || (k == 2 && o == 6'b000000)) begin
                bus.op    = o;
                bus.funct = f;
            end else begin
                bus.op    = 6'($urandom_range(0, 63));
                bus.funct = 6'($urandom_range(0, 63));
            end
            z = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
            bus.zero = z;
            @(negedge clk);
            checkOutput($sformatf("op=%b funct=%b cyc=%0d", o, f, k + 1), model(o, f, z, k));
            if (k == abortAt) begin
                reset_n = 1'b0;
                @(posedge clk);
                #1;
                reset_n  = 1'b1;
                bus.zero = 1'b1;
                @(negedge clk);
                checkOutput("abort_reset", 15'b0);
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [5:0] ops [7];
        logic [5:0] rfun [4];
        logic [5:0] o;
        logic [5:0] f;
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        bus.op    = 6'b0;
        bus.funct = 6'b0;
        bus.zero  = 1'b1;
        ops  = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010, 6'b111111};
        rfun = '{6'b100010, 6'b100101, 6'b101010, 6'b111111};

        // Reset held for three edges: outputs all zero, even with zero=1.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bus.op = 6'($urandom_range(0, 63));
            @(negedge clk);
            checkOutput("reset_hold", 15'b0);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed sequence.
        applyStimulus(6'b100011, 6'b000000, -1, -1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(6'b000000, rfun[i], -1, -1);
        end
        applyStimulus(6'b000100, 6'b000000, 1, -1);
        applyStimulus(6'b000100, 6'b000000, 0, -1);
        applyStimulus(6'b101011, 6'b000000, -1, -1);
        applyStimulus(6'b000010, 6'b000000, -1, -1);
        applyStimulus(6'b111111, 6'b000000, -1, -1);
        applyStimulus(6'b001000, 6'b000000, -1, -1);

        // lw aborted by reset in its MEMRD cycle, then a normal lw.
        applyStimulus(6'b100011, 6'b000000, -1, 3);
        applyStimulus(6'b100011, 6'b000000, -1, -1);

        // Random instruction mix, including arbitrary unknown opcodes.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                o = 6'($urandom_range(0, 63));
            end else begin
                o = ops[$urandom_range(0, 6)];
            end
            if ($urandom_range(0, 1) == 0) begin
                f = rfun[$urandom_range(0, 3)];
            end else begin
                f = 6'($urandom_range(0, 63));
            end
            applyStimulus(o, f, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
